// File: rtl/first_nios2_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// first_nios2_system_sysid_checker
//
// Reads the two words of a system-ID peripheral over Avalon-MM (address 0 = ID,
// address 1 = build timestamp) and compares each against its expected value.
// A check runs automatically after reset and again after every start pulse
// that arrives while idle or done. A read held off by waitrequest for too long
// aborts the check with timeout set.
//
// Ports
//   clock            single clock, rising edge
//   reset            asynchronous, active-high
//   start            one-cycle request to re-run the check (ignored while busy)
//   avm_address      word select: 0 = ID, 1 = timestamp
//   avm_read         read request, held stable while avm_waitrequest is high
//   avm_waitrequest  slave stall; a read is accepted when read=1, waitrequest=0
//   avm_readdata     slave read data
//   busy             a check is in progress
//   done             level; the last check has completed
//   id_ok / ts_ok    captured word equals its expected value
//   timeout          the last check was aborted by a stall
//   captured_id/_ts  last captured words, held until overwritten
// -----------------------------------------------------------------------------
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1518032159,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [1:0]  LatCycles    = 2'(READ_LATENCY);
    localparam bit          HasLatency   = (READ_LATENCY != 0);
    localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);
    localparam bit          TimeoutEn    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        StIdle,
        StReqId,
        StLatId,
        StReqTs,
        StLatTs,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;

    // Compared one bit wider so a limit of 65535 is still reachable.
    logic [16:0] stall_next;
    logic        stall_hit;

    assign stall_next = {1'b0, stall_q} + 17'd1;
    assign stall_hit  = TimeoutEn && (stall_next == TimeoutLimit);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        stall_d   = stall_q;
        lat_d     = lat_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (pending_q) begin
                    state_d   = StReqId;
                    pending_d = 1'b0;
                    stall_d   = '0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StReqId: begin
                if (!avm_waitrequest) begin
                    if (HasLatency) begin
                        state_d = StLatId;
                        lat_d   = 2'd1;
                    end else begin
                        state_d  = StReqTs;
                        stall_d  = '0;
                        cap_id_d = avm_readdata;
                        id_ok_d  = (avm_readdata == EXPECTED_ID);
                    end
                end else begin
                    stall_d = stall_next[15:0];
                    if (stall_hit) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            StLatId: begin
                // lat_q counts edges since acceptance; data is valid on the last one.
                if (lat_q == LatCycles) begin
                    state_d  = StReqTs;
                    lat_d    = '0;
                    stall_d  = '0;
                    cap_id_d = avm_readdata;
                    id_ok_d  = (avm_readdata == EXPECTED_ID);
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StReqTs: begin
                if (!avm_waitrequest) begin
                    if (HasLatency) begin
                        state_d = StLatTs;
                        lat_d   = 2'd1;
                    end else begin
                        state_d  = StDone;
                        cap_ts_d = avm_readdata;
                        ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
                    end
                end else begin
                    stall_d = stall_next[15:0];
                    if (stall_hit) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            StLatTs: begin
                if (lat_q == LatCycles) begin
                    state_d  = StDone;
                    lat_d    = '0;
                    cap_ts_d = avm_readdata;
                    ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A start landing on the edge that finishes a check is kept, not lost;
        // starts while a check stays in flight are dropped.
        if (start && (state_d == StDone || state_d == StIdle)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b1;
            stall_q   <= '0;
            lat_q     <= '0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
            lat_q     <= lat_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    // Bus controls decode straight from state, so they are stable while stalled.
    always_comb begin
        avm_read    = (state_q == StReqId) || (state_q == StReqTs);
        avm_address = (state_q == StReqTs);
        busy        = (state_q == StReqId) || (state_q == StLatId) ||
                      (state_q == StReqTs) || (state_q == StLatTs);
        done        = (state_q == StDone);
    end

    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: doc/first_nios2_system_sysid_checker.md
FIRST_NIOS2_SYSTEM_SYSID_CHECKER -- requirements
Module: first_nios2_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, expected 32-bit word at sysid address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1518032159, expected 32-bit word at sysid address 1.
REQ-003 Parameter READ_LATENCY, default 0, range 0..3, cycles from read acceptance to valid readdata.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, range 0..65535, maximum consecutive waitrequest cycles per read; 0 disables the timeout.
REQ-005 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port start  in  1  one-cycle request to re-run the check.
REQ-008 Port avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-009 Port avm_read  out  1  Avalon-MM read request.
REQ-010 Port avm_waitrequest  in  1  slave stall; the read is accepted on an edge where avm_read=1 and avm_waitrequest=0.
REQ-011 Port avm_readdata  in  32  slave read data.
REQ-012 Port busy  out  1  a check is in progress.
REQ-013 Port done  out  1  level; the last check has completed.
REQ-014 Port id_ok / ts_ok  out  1 each  the captured word equals its expected value.
REQ-015 Port timeout  out  1  the last check was aborted by a stall.
REQ-016 Port captured_id / captured_ts  out  32 each  the last captured words.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, DONE.
REQ-018 An internal pending flag SHALL be set by reset and by start; in IDLE or DONE with pending=1, the next edge SHALL enter REQ_ID and clear pending, done, id_ok, ts_ok and timeout.
REQ-019 In REQ_ID and REQ_TS, avm_read=1 and avm_address=0 or 1 respectively; in all other states avm_read=0 and avm_address=0.
REQ-020 avm_read and avm_address SHALL be held stable while avm_waitrequest=1.
REQ-021 On acceptance with READ_LATENCY=0, avm_readdata SHALL be captured on the acceptance edge and the FSM SHALL advance (REQ_ID->REQ_TS, REQ_TS->DONE).
REQ-022 On acceptance with READ_LATENCY=N>0, the FSM SHALL enter LAT_x, count N edges and capture avm_readdata on the Nth edge after acceptance, then advance.
REQ-023 id_ok and ts_ok SHALL be registered on their capture edge as (avm_readdata == expected value), comparing all 32 bits.
REQ-024 The stall counter (16 bits) SHALL clear on entry to each REQ state and increment on each edge in that REQ state with avm_waitrequest=1.
REQ-025 When TIMEOUT_CYCLES>0 and the stall counter reaches TIMEOUT_CYCLES, the FSM SHALL enter DONE with timeout=1, and any ok flag not yet captured SHALL remain 0.
REQ-026 busy=1 in REQ_ID, LAT_ID, REQ_TS and LAT_TS, else 0; done=1 only in DONE.
REQ-027 start while busy=1 SHALL be ignored; start on the same edge the FSM enters DONE SHALL set pending.
REQ-028 captured_id and captured_ts SHALL hold their values until overwritten by a later capture.
REQ-029 Nominal timing SHALL be as follows: with READ_LATENCY=0 and no stall, done rises on the 3rd edge after reset deassertion.

Reset
REQ-030 Asserting reset SHALL immediately force: state IDLE, pending=1, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, captured_id=0, captured_ts=0, stall and latency counters 0.
REQ-031 Reset asserted mid-read SHALL abandon the transaction with no capture; after release, the check restarts from REQ_ID.

Verification
REQ-032 Scenario: defaults, slave returns 0 and 1518032159, no stalls -> done=1 on the 3rd edge after release, id_ok=1, ts_ok=1, timeout=0.
REQ-033 Scenario: timestamp read returns 0x5A7B0000 -> captured_ts=0x5A7B0000, ts_ok=0, id_ok=1, done=1.
REQ-034 Scenario: READ_LATENCY=2, waitrequest high 3 cycles per read -> address held stable while stalled, data captured exactly 2 edges after acceptance, both ok flags=1.
REQ-035 Scenario: TIMEOUT_CYCLES=4, waitrequest stuck high on the ID read -> DONE after 4 stalled edges, timeout=1, id_ok=0, ts_ok=0, avm_read=0.
REQ-036 Scenario: start pulsed while busy, then again in DONE -> first pulse ignored; second pulse clears done/flags and a full re-check completes.
REQ-037 Scenario: reset pulsed during LAT_TS -> all outputs return to reset values asynchronously, and a full check completes after release.
